// File: rtl/data_sram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_sram_bridge
//  Purpose  : MEM-stage data access responder. Turns the datapath's level
//             access request into one SRAM-like bus transaction
//             (req / addr_ok / data_ok), holds the pipeline while the access
//             is in flight and returns load data on mem_rdata.
//  Ports    :
//    clk, rst            - clock, synchronous active-low reset
//    mem_en, mem_we      - access request (level) and store select
//    mem_addr            - virtual byte address
//    mem_wdata_last      - lane-aligned store data
//    sel, mem_size       - byte enables, access size (0 byte,1 half,2 word)
//    cpu_longest_stall   - other stages are holding the pipeline
//    mem_rdata           - load data back to the MEM stage
//    stallreq_from_mem   - hold request to the hazard unit
//    data_req/wr/size/addr/wdata/wstrb - bus request side (registered)
//    data_addr_ok, data_data_ok, data_rdata - bus response side
//  Revision : 1.0 - initial release
// ============================================================================
module data_sram_bridge #(
   parameter logic MAP_KSEG = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata_last,
   input  logic [3:0]  sel,
   input  logic [1:0]  mem_size,
   input  logic        cpu_longest_stall,
   output logic [31:0] mem_rdata,
   output logic        stallreq_from_mem,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_req;
   logic        r_wr;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_rdata;
   logic [31:0] w_paddr;

   // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) both alias physical
   // memory from 0; dropping the top three bits performs the translation.
   generate
      if (MAP_KSEG) begin : g_kseg_map
         always_comb begin
            w_paddr = mem_addr;
            if (mem_addr[31:30] == 2'b10) begin
               w_paddr = {3'b000, mem_addr[28:0]};
            end
         end
      end else begin : g_no_map
         always_comb begin
            w_paddr = mem_addr;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_wr    <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_wstrb <= 4'd0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mem_en) begin
                  // Latch everything so the bus sees stable values even if
                  // the datapath inputs wiggle while the request is pending.
                  r_wr    <= mem_we;
                  r_size  <= mem_size;
                  r_addr  <= w_paddr;
                  r_wdata <= mem_wdata_last;
                  r_wstrb <= sel;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (data_addr_ok) begin
                  r_req   <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (data_data_ok) begin
                  if (!r_wr) begin
                     r_rdata <= data_rdata;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Stay here while another stage freezes the pipeline, so the
               // still-present mem_en is not mistaken for a new access.
               if (!cpu_longest_stall) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Combinational so the hold takes effect in the cycle mem_en first rises.
   assign stallreq_from_mem = mem_en & (r_state != S_DONE);

   assign mem_rdata  = r_rdata;
   assign data_req   = r_req;
   assign data_wr    = r_wr;
   assign data_size  = r_size;
   assign data_addr  = r_addr;
   assign data_wdata = r_wdata;
   assign data_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: doc/data_sram_bridge.md
# data_sram_bridge

Data-side memory responder for the pipeline's MEM stage. It accepts the datapath's single-cycle data access (`mem_en`, `mem_we`, `sel`, `mem_size`, `mem_wdata_last`, ALU address) and holds the pipeline with `stallreq_from_mem` while it runs the access as the initiator on an SRAM-like bus (`req` / `addr_ok` / `data_ok`). It then returns read data on `mem_rdata`. It sits between the datapath's MEM stage and the data bus/cache interconnect.

## Interface
- `MAP_KSEG`, default 1: when 1, addresses in kseg0/kseg1 (`addr[31:29]` = 3'b100 or 3'b101) are translated to physical by clearing bits [31:29]; when 0, the address passes through unchanged.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `mem_en` in 1: MEM-stage access request, level, held while stalled.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: virtual byte address (MEM-stage ALU result).
- `mem_wdata_last` in 32: byte-lane-aligned store data.
- `sel` in 4: byte enables (informational; passed as `data_wstrb`).
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word.
- `cpu_longest_stall` in 1: OR of all other stage stall requests; the pipeline is held while it is high.
- `mem_rdata` out 32: load data returned to the MEM stage.
- `stallreq_from_mem` out 1: hold request to hazard unit.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write.
- `data_size` out 2: bus size.
- `data_addr` out 32: physical address.
- `data_wdata` out 32: bus write data.
- `data_wstrb` out 4: bus byte strobes.
- `data_addr_ok` in 1: request accepted this cycle.
- `data_data_ok` in 1: read data valid / write complete this cycle.
- `data_rdata` in 32: bus read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `mem_en` = 1: latch `data_wr`/`data_size`/`data_addr` (mapped)/`data_wdata`/`data_wstrb` from the CPU inputs, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `data_req` = 1, with all bus outputs driven from the latched registers and held stable.
  - When `data_addr_ok` = 1, go to WAIT.
- WAIT:
  - `data_req` = 0.
  - When `data_data_ok` = 1: if the access is a read, capture `data_rdata` into `mem_rdata`; then go to DONE.
  - `data_data_ok` in any state other than WAIT is ignored.
- DONE:
  - Access complete; `mem_rdata` is held.
  - If `cpu_longest_stall` = 0, go to IDLE. Otherwise stay, so the same instruction is never re-issued while the pipeline is frozen by another stage.
- `stallreq_from_mem` = `mem_en` & (state != DONE). It is combinational, so it asserts in the same cycle `mem_en` first rises.
- Stores leave `mem_rdata` unchanged.
- Address map (MAP_KSEG = 1): 0x8000_0100 → 0x0000_0100, 0xBFC0_0000 → 0x1FC0_0000, 0x0040_0000 → unchanged.

## Timing
- Reset (`rst` = 0 at an edge):
  - State goes to IDLE.
  - `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_wstrb` and `mem_rdata` are all 0.
  - `stallreq_from_mem` follows its equation, so it is `mem_en` while in IDLE.
- Reset in REQ/WAIT abandons the bus transaction; the interconnect is reset simultaneously.
- Minimum latency, with `mem_en` rising in cycle 0, `addr_ok` in cycle 1 and `data_ok` in cycle 2:
  - Stall is high in cycles 0–2.
  - DONE in cycle 3, with stall low and `mem_rdata` valid.
  - IDLE in cycle 4 if `cpu_longest_stall` = 0 in cycle 3.
- Each cycle of `addr_ok` or `data_ok` delay adds one stall cycle.
- `data_addr_ok` and `data_data_ok` never complete the same request in the same cycle; `data_ok` is only sampled in WAIT.
- Only one outstanding transaction at a time.
- If `mem_en` drops while in REQ (only possible under reset or flush misuse), the bridge still completes the transaction; there is no cancel path.
- `mem_en` = 1 in DONE with `cpu_longest_stall` = 0 is the same instruction leaving MEM. The next access starts from IDLE in the following cycle.

## Test plan
- Load word: `mem_addr` = 0x8000_0010, `addr_ok` in cycle 1, `data_ok` with `data_rdata` = 0xDEADBEEF in cycle 2.
  - Required: `data_addr` = 0x0000_0010, `data_req` high only in cycle 1, stall high in cycles 0–2.
  - Required in cycle 3: `mem_rdata` = 0xDEADBEEF, stall = 0.
- Store byte: `mem_we` = 1, `mem_size` = 0, `sel` = 4'b0100, `mem_wdata_last` = 0x00AB0000.
  - Required: `data_wr` = 1, `data_size` = 0, `data_wstrb` = 4'b0100, `data_wdata` = 0x00AB0000.
  - Required: `mem_rdata` unchanged after completion.
- Delayed handshake: `addr_ok` withheld for 3 cycles, then `data_ok` 2 cycles after acceptance.
  - Required: `data_req` high for 4 cycles with stable address/data.
  - Required: stall high for 7 cycles total.
- Foreign stall: `cpu_longest_stall` = 1 for 4 cycles after DONE.
  - Required: state stays DONE, stall stays 0, no second `data_req`, `mem_rdata` held.
  - Required: returns to IDLE the cycle after `cpu_longest_stall` = 0.
- Mapping with MAP_KSEG = 1: 0xBFC0_0000 → 0x1FC0_0000, 0x0040_0000 → 0x0040_0000. With MAP_KSEG = 0: 0xBFC0_0000 passes through unchanged.
- Reset in WAIT: assert `rst` = 0 for 1 cycle.
  - Required: all bus outputs and `mem_rdata` = 0 and state = IDLE.
  - Required: a later spurious `data_ok` while in IDLE is ignored.
